// File: rtl/alu_mul_sequencer_if.sv
// Bundle between the core datapath, the shared ALU and the multiply sequencer.
// The sequencer uses the slave modport; the core/ALU side uses master.
interface alu_mul_sequencer_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            start;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] core_a;
  logic [XLEN-1:0] core_b;
  logic [3:0]      core_alu_control;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] alu_result;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] product;

  modport slave (
    input  start, op_a, op_b, core_a, core_b, core_alu_control, alu_result,
    output alu_a, alu_b, alu_control, busy, done, product
  );

  modport master (
    output start, op_a, op_b, core_a, core_b, core_alu_control, alu_result,
    input  alu_a, alu_b, alu_control, busy, done, product
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add MUL sequencer that borrows the core's shared ALU for the additions.
// Passes core ALU operands through whenever it is not in RUN.
module alu_mul_sequencer #(
  parameter int unsigned XLEN    = 64,
  parameter logic [3:0]  ALU_ADD = 4'b0000
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_mul_sequencer_if.slave  bus
);
  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state; a zero multiplier skips RUN entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = (bus.op_b != '0) ? StRun : StDone;
      end
      StRun: begin
        if (((mplier_q >> 1) == '0) || (cnt_q == CntLast)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers; start outside IDLE has no effect.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (state_q == StIdle && bus.start) begin
      acc_d    = '0;
      mcand_d  = bus.op_a;
      mplier_d = bus.op_b;
      cnt_d    = '0;
    end else if (state_q == StRun) begin
      if (mplier_q[0]) acc_d = bus.alu_result;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    bus.alu_a       = bus.core_a;
    bus.alu_b       = bus.core_b;
    bus.alu_control = bus.core_alu_control;
    if (state_q == StRun) begin
      bus.alu_a       = acc_q;
      bus.alu_b       = mcand_q;
      bus.alu_control = ALU_ADD;
    end
    bus.busy    = (state_q != StIdle);
    bus.done    = (state_q == StDone);
    bus.product = acc_q;
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: a scoreboard of a*b products checked on done,
// plus RUN length, ALU ownership, ignored starts and asynchronous reset.
module tb_alu_mul_sequencer;
  localparam int unsigned XLEN = 64;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [XLEN-1:0] exp_q[$];

  alu_mul_sequencer_if #(.XLEN(XLEN)) bus ();

  alu_mul_sequencer #(.XLEN(XLEN), .ALU_ADD(4'b0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared ALU model: ADD for 0000, SUB otherwise.
  assign bus.alu_result = (bus.alu_control == 4'b0000) ? bus.alu_a + bus.alu_b
                                                       : bus.alu_a - bus.alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic int run_len(input logic [XLEN-1:0] b);
    for (int i = XLEN - 1; i >= 0; i--) if (b[i]) return i + 1;
    return 0;
  endfunction

  // Called on a negedge in IDLE; returns on the negedge of the first IDLE cycle after done.
  // inject >= 0 pulses an ignored start (9*9) in that RUN cycle.
  task automatic run_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input int inject);
    int runs;
    logic [XLEN-1:0] exp;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    exp_q.push_back(a * b);
    @(negedge clk);
    bus.start = 1'b0;
    runs = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) break;
      check("run_alu_control", {60'd0, bus.alu_control}, 64'd0);
      check("run_busy", {63'd0, bus.busy}, 64'd1);
      bus.start = (runs == inject);
      bus.op_a  = 64'd9;
      bus.op_b  = 64'd9;
      bus.core_alu_control = 4'b0001;
      runs++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_seen", {63'd0, bus.done}, 64'd1);
    check("run_cycles", 64'(runs), 64'(run_len(b)));
    check("done_busy", {63'd0, bus.busy}, 64'd1);
    check("done_passthrough_ctl", {60'd0, bus.alu_control}, {60'd0, bus.core_alu_control});
    check("sb_not_empty", 64'(exp_q.size()), 64'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    if (bus.done) check("product", bus.product, exp);
    @(negedge clk);
    check("idle_busy", {63'd0, bus.busy}, 64'd0);
    check("idle_done", {63'd0, bus.done}, 64'd0);
    check("product_hold", bus.product, exp);
  endtask

  initial begin
    int saw_done;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.core_a = 64'hA;
    bus.core_b = 64'h3;
    bus.core_alu_control = 4'b0001;
    repeat (2) @(negedge clk);
    check("rst_product", bus.product, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("pass_a", bus.alu_a, 64'hA);
    check("pass_b", bus.alu_b, 64'h3);
    check("pass_ctl", {60'd0, bus.alu_control}, 64'd1);

    run_mul(64'd5, 64'd3, -1);
    run_mul(64'h123, 64'd0, -1);
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, -1);
    run_mul(64'd1, 64'h8000_0000_0000_0000, -1);
    run_mul(64'd7, 64'h10, 2);
    // Start in the cycle right after done must be accepted.
    run_mul(64'hDEAD_BEEF, 64'h1_0001, -1);

    // Asynchronous reset mid-RUN of 0xFF*0xFF.
    bus.start = 1'b1;
    bus.op_a  = 64'hFF;
    bus.op_b  = 64'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.core_a = 64'h55;
    bus.core_b = 64'h66;
    bus.core_alu_control = 4'b0010;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_product", bus.product, 64'd0);
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_done", {63'd0, bus.done}, 64'd0);
    check("arst_pass_a", bus.alu_a, 64'h55);
    check("arst_pass_ctl", {60'd0, bus.alu_control}, 64'd2);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
    end
    check("no_done_after_rst", 64'(saw_done), 64'd0);
    check("post_rst_pass_b", bus.alu_b, 64'h66);
    run_mul(64'd6, 64'd7, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
